// File: rtl/dm_param.sv
// Parametrised single-port data memory for the RV32I MEM stage: byte/half/word
// loads and stores with extension, fault detection and configurable wait states.
module dm_param #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              fault
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int CNT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] CNT_INIT = CNT_I[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] idx;
  logic [1:0]        lane;
  logic              illegal, misaligned, acc_fault;
  logic [3:0]        be;
  logic [31:0]       wd, rword, shifted, load_val, result;
  logic [31:0]       pend_rdata, rdata_q;
  logic              pend_fault, fault_q;

  assign accept = req && ready;
  assign idx    = addr[ADDR_W-1:2];
  assign lane   = addr[1:0];

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be         = 4'hF;
    wd         = wdata;
    case (funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = we;
      default:                illegal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << lane;
        wd         = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      default: misaligned = (lane != 2'b00);
    endcase
    acc_fault = illegal || misaligned;
  end

  // Load path: select the lane, then extend according to size and signedness.
  always_comb begin
    rword   = mem[idx];
    shifted = rword >> {lane, 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      3'b010:  load_val = rword;
      default: load_val = 32'h0;
    endcase
    result = (we || acc_fault) ? 32'h0 : load_val;
  end

  // NOTE: the storage array has no reset; only control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && accept && we && !acc_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept)              state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        else if (state == S_RESP) state_nxt = S_IDLE;
      end
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      pend_rdata <= 32'h0;
      pend_fault <= 1'b0;
      rdata_q    <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= CNT_INIT;
        pend_rdata <= result;
        pend_fault <= acc_fault;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // rdata only changes on entry to RESP so it holds its last value otherwise.
      if (state_nxt == S_RESP) begin
        rdata_q <= (state == S_WAIT) ? pend_rdata : result;
        fault_q <= (state == S_WAIT) ? pend_fault : acc_fault;
      end
    end
  end

  assign ready      = (state != S_WAIT);
  assign resp_valid = (state == S_RESP);
  assign rdata      = rdata_q;
  assign fault      = resp_valid && fault_q;

endmodule

// File: tb/tb_dm_param.sv
// Self-checking bench for dm_param: two instances (0 and 3 wait states) checked
// every cycle against a byte-array reference model, plus directed literal cases.
module tb_dm_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_s        [2];
  logic        we_s         [2];
  logic [2:0]  f3_s         [2];
  logic [9:0]  addr_s       [2];
  logic [31:0] wdata_s      [2];
  logic        ready_s      [2];
  logic        resp_valid_s [2];
  logic [31:0] rdata_s      [2];
  logic        fault_s      [2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  dm_param #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dm0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .funct3(f3_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]),
    .resp_valid(resp_valid_s[0]), .rdata(rdata_s[0]), .fault(fault_s[0]));

  dm_param #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dm3 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .funct3(f3_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]),
    .resp_valid(resp_valid_s[1]), .rdata(rdata_s[1]), .fault(fault_s[1]));

  function automatic int wc(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: little-endian byte array, one outstanding access per instance,
  // response due WAIT_CYCLES edges after the acceptance edge.
  logic [7:0]  mm [2][1024];
  logic        pend    [2] = '{1'b0, 1'b0};
  int          due     [2] = '{0, 0};
  logic [31:0] p_rd    [2] = '{32'h0, 32'h0};
  logic        p_f     [2] = '{1'b0, 1'b0};
  logic [31:0] hold_rd [2] = '{32'h0, 32'h0};
  logic        rdy_b   [2];

  task automatic model_exec(input int i, input logic w, input logic [2:0] f,
                            input logic [9:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic flt);
    int n;
    logic [31:0] v;
    n   = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    flt = (f == 3'd3) || (f >= 3'd6) || (w && f[2]) || ((int'(a) % n) != 0);
    rd  = 32'h0;
    if (!flt) begin
      if (w) begin
        for (int k = 0; k < n; k++) mm[i][int'(a) + k] = d[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mm[i][int'(a) + k];
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pend[i]    = 1'b0;
        hold_rd[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) rdy_b[i] = !pend[i] || (cyc >= due[i]);
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && cyc > due[i]) pend[i] = 1'b0;
        if (req_s[i] && rdy_b[i]) begin
          model_exec(i, we_s[i], f3_s[i], addr_s[i], wdata_s[i], p_rd[i], p_f[i]);
          pend[i] = 1'b1;
          due[i]  = cyc + wc(i);
        end
        if (pend[i] && cyc == due[i]) hold_rd[i] = p_rd[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready[%0d]", i), ready_s[i], !pend[i] || (cyc >= due[i]));
      check($sformatf("resp_valid[%0d]", i), resp_valid_s[i], pend[i] && (cyc == due[i]));
      check($sformatf("fault[%0d]", i), fault_s[i], pend[i] && (cyc == due[i]) && p_f[i]);
      check($sformatf("rdata[%0d]", i), rdata_s[i], hold_rd[i]);
    end
  end

  // Drive a request and hold req until accepted; returns just after the acceptance edge.
  task automatic issue(input int i, input logic w, input logic [2:0] f, input logic [9:0] a,
                       input logic [31:0] d, output int acc);
    req_s[i] = 1'b1; we_s[i] = w; f3_s[i] = f; addr_s[i] = a; wdata_s[i] = d;
    acc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_s[i]) begin
        acc = cyc;
        @(posedge clk); #1;
        break;
      end
    end
    check($sformatf("accept[%0d]", i), acc >= 0, 1'b1);
  endtask

  task automatic wait_resp(input int i, output int rc, output logic [31:0] rd, output logic flt);
    rc = -1; rd = 32'hxxxx_xxxx; flt = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid_s[i]) begin
        rc = cyc; rd = rdata_s[i]; flt = fault_s[i];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic t_expect(input string name, input int i, input logic w, input logic [2:0] f,
                          input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_f);
    int acc, rc;
    logic [31:0] rd;
    logic flt;
    issue(i, w, f, a, d, acc);
    req_s[i] = 1'b0;
    wait_resp(i, rc, rd, flt);
    check({name, " rdata"}, rd, exp_rd);
    check({name, " fault"}, flt, exp_f);
    check({name, " latency"}, rc - acc, wc(i) + 1);
  endtask

  initial begin
    int acc, acc2, rc;
    logic [31:0] rd;
    logic flt;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; f3_s[i] = 3'b010; addr_s[i] = '0; wdata_s[i] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("reset ready", ready_s[i], 1'b1);
      check("reset resp_valid", resp_valid_s[i], 1'b0);
      check("reset rdata", rdata_s[i], 32'h0);
      check("reset fault", fault_s[i], 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    t_expect("SW 0x10", 0, 1'b1, 3'b010, 10'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    t_expect("LW 0x10", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    t_expect("LB 0x13", 0, 1'b0, 3'b000, 10'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
    t_expect("LBU 0x13", 0, 1'b0, 3'b100, 10'h13, 32'h0, 32'h0000_00DE, 1'b0);
    t_expect("LH 0x10", 0, 1'b0, 3'b001, 10'h10, 32'h0, 32'hFFFF_BEEF, 1'b0);
    t_expect("LHU 0x12", 0, 1'b0, 3'b101, 10'h12, 32'h0, 32'h0000_DEAD, 1'b0);
    t_expect("SB 0x11", 0, 1'b1, 3'b000, 10'h11, 32'h0000_0055, 32'h0, 1'b0);
    t_expect("LW after SB", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_55EF, 1'b0);
    t_expect("LW 0x12 misaligned", 0, 1'b0, 3'b010, 10'h12, 32'h0, 32'h0, 1'b1);
    t_expect("SH 0x11 misaligned", 0, 1'b1, 3'b001, 10'h11, 32'hFFFF_FFFF, 32'h0, 1'b1);
    t_expect("LW after bad SH", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_55EF, 1'b0);
    t_expect("funct3 011", 0, 1'b0, 3'b011, 10'h10, 32'h0, 32'h0, 1'b1);
    t_expect("SBU illegal", 0, 1'b1, 3'b100, 10'h10, 32'h0, 32'h0, 1'b1);

    // Back-to-back store then load at zero wait states.
    issue(0, 1'b1, 3'b010, 10'h14, 32'hCAFE_F00D, acc);
    issue(0, 1'b0, 3'b010, 10'h14, 32'h0, acc2);
    req_s[0] = 1'b0;
    check("b2b accept spacing", acc2 - acc, 1);
    wait_resp(0, rc, rd, flt);
    check("b2b LW rdata", rd, 32'hCAFE_F00D);
    check("b2b LW latency", rc - acc2, 1);

    // Three wait states: ready low for three cycles, req held through WAIT is taken in RESP.
    t_expect("W3 SW 0x10", 1, 1'b1, 3'b010, 10'h10, 32'h0102_0304, 32'h0, 1'b0);
    issue(1, 1'b0, 3'b010, 10'h10, 32'h0, acc);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("W3 ready t+%0d", k), ready_s[1], 1'b0);
      check($sformatf("W3 resp t+%0d", k), resp_valid_s[1], 1'b0);
    end
    @(negedge clk);
    check("W3 resp t+4", resp_valid_s[1], 1'b1);
    check("W3 resp cycle", cyc - acc, 4);
    check("W3 rdata", rdata_s[1], 32'h0102_0304);
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    wait_resp(1, rc, rd, flt);
    check("W3 held req response cycle", rc - acc, 8);
    check("W3 held req rdata", rd, 32'h0102_0304);

    // Reset while a store response is pending.
    issue(1, 1'b1, 3'b010, 10'h20, 32'h1234_5678, acc);
    req_s[1] = 1'b0;
    @(negedge clk);
    check("pre-reset in WAIT", ready_s[1], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset ready immediate", ready_s[1], 1'b1);
    check("reset resp dropped", resp_valid_s[1], 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("resp stays low in reset", resp_valid_s[1], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    t_expect("LW 0x20 after reset", 1, 1'b0, 3'b010, 10'h20, 32'h0, 32'h1234_5678, 1'b0);

    // Fill the random window so every load reads defined data.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 16; w++) begin
        t_expect("init SW", i, 1'b1, 3'b010, 10'(w * 4), $urandom, 32'h0, 1'b0);
      end
    end

    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_s[i]   = ($urandom_range(0, 3) != 0);
        we_s[i]    = 1'($urandom_range(0, 1));
        f3_s[i]    = 3'($urandom_range(0, 7));
        addr_s[i]  = 10'($urandom_range(0, 63));
        wdata_s[i] = $urandom;
      end
      rst_n = (k != 400);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) req_s[i] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_param.md
Name: dm_param

Overview:
- Parametrised successor to the single-port 32-bit data memory of the RISC-V core.
- Byte-addressed, word-organised storage with byte, half and word loads and stores, encoded by RV32I funct3.
- Sign and zero extension on loads; misalignment and illegal-size faults.
- req/ready request handshake plus a one-cycle response pulse, with configurable wait states. It sits between the core's MEM stage and the register-file writeback.

Parameters:
ADDR_W, 10, byte-address width; depth = 2**(ADDR_W-2) 32-bit words
WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request
we  input  1  1 = store, 0 = load
funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
addr  input  ADDR_W  byte address
wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
ready  output  1  block can accept a request this cycle
resp_valid  output  1  one-cycle response pulse
rdata  output  32  extended load data; 0 for stores and faults
fault  output  1  qualifies resp_valid: access was misaligned or illegal

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset state:
  - state=IDLE; ready=1; resp_valid=0; rdata=0; fault=0; wait counter=0.
  - Memory contents are not cleared by reset.
- Acceptance: a request is accepted on a rising edge where req && ready.
- States: IDLE, WAIT, RESP.
  - IDLE: ready=1. On accept, go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: ready=0. Counter loads WAIT_CYCLES-1 on accept and decrements each cycle. At 0, go to RESP.
  - RESP: resp_valid=1 and ready=1 for exactly one cycle. On accept (back-to-back), go to WAIT or RESP as from IDLE; otherwise go to IDLE.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
  - With WAIT_CYCLES=0, one access per cycle is sustained.
- Word index is addr[ADDR_W-1:2]; byte lane is addr[1:0].
- Fault check at acceptance:
  - H/HU/SH require addr[0]=0.
  - W/SW require addr[1:0]=0.
  - funct3 011, 110 and 111 are illegal.
  - Stores with funct3 100 or 101 are illegal.
  - A faulting access writes nothing and responds with fault=1, rdata=0.
- Stores:
  - The memory write commits on the acceptance edge, using byte enables derived from size and lane.
  - Untouched bytes keep their value.
  - Store response: fault per check, rdata=0.
- Loads:
  - The addressed word is sampled on the acceptance edge, then lane-selected and extended.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W is passed through.
  - The result is held internally and presented on rdata during RESP.
- Outputs outside RESP: rdata holds its last value; fault=0.
- Store-then-load to the same address back-to-back: the load returns the newly stored data, because the write commits at its own acceptance edge, one edge earlier.
- req while ready=0: ignored, not queued; the requester must hold req.
- Reset mid-operation:
  - The pending response is dropped immediately and the block returns to the reset state.
  - A store already accepted remains in memory.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 (WAIT_CYCLES=0) -> resp_valid 1 cycle after each accept; LW rdata=0xDEADBEEF, fault=0.
- Word 0x10=0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata=0x00000055 on 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
- Misaligned and illegal accesses:
  - LW 0x12 -> fault=1, rdata=0.
  - SH 0x11 -> fault=1, and word 0x10 unchanged on a later LW.
  - funct3=011 -> fault=1.
- WAIT_CYCLES=3:
  - LW accepted at cycle t -> ready=0 for t+1..t+3; resp_valid at t+4 only.
  - req held high during WAIT is accepted in RESP.
- rst_n low in WAIT after SW 0x20=0x12345678 -> resp_valid never asserts, ready=1 immediately; after release, LW 0x20 -> 0x12345678.
